// File: rtl/cruise_pkg.sv
// cruise_pkg: shared speed width, saturation value and sampler FSM encoding for the cruise-control path.
package cruise_pkg;
  localparam int SPEED_W = 8;
  localparam logic [SPEED_W-1:0] SPEED_MAX = 8'hFF;
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, MEASURE = 2'd2} state_t;
endpackage

// File: rtl/wheel_speed_sampler_tick_sync.sv
// tick_sync: brings the asynchronous wheel tick into the clock domain and flags each rising edge.
module tick_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  input  logic arm,
  output logic rise_pulse
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_level;
  assign w_level = r_sync[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= w_level;
    end
  end
  // history always follows the synced level; arm also masks the edge so a tick high at start is not counted
  assign rise_pulse = w_level & ~r_prev & ~arm;
endmodule

// File: rtl/wheel_speed_sampler.sv
// wheel_speed_sampler: counts wheel-tick edges per fixed window and publishes a saturated 8-bit speed.
module wheel_speed_sampler
  import cruise_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  input  logic               wheel_tick,
  output logic [SPEED_W-1:0] speed,
  output logic               speed_valid,
  output logic               overflow,
  output logic               cmp_enable
);
  localparam int WC_W = $clog2(WINDOW_CYCLES);
  state_t             r_state, w_next;
  logic [WC_W-1:0]    r_win;
  logic [8:0]         r_pulse;
  logic [SPEED_W-1:0] r_speed;
  logic               r_valid, r_ovf, r_cmp;
  logic               w_rise, w_term, w_pub, w_count;
  logic [8:0]         w_total;
  tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .async_in   (wheel_tick),
    .arm        (r_state == ARM),
    .rise_pulse (w_rise)
  );
  always_comb begin
    w_next = !run ? IDLE : (r_state == IDLE ? ARM : MEASURE);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end
  // r_pulse sticks at 256 so a saturated window is still recognisable at publish time
  assign w_total = r_pulse + {8'd0, w_rise};
  assign w_term  = (r_state == MEASURE) && (r_win == WC_W'(WINDOW_CYCLES - 1));
  assign w_pub   = w_term && run;
  assign w_count = (r_state == MEASURE) && run && !w_term;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_win   <= '0;
      r_pulse <= '0;
      r_speed <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_cmp   <= 1'b0;
    end else begin
      r_win   <= w_count ? r_win + WC_W'(1) : '0;
      r_pulse <= w_count ? (r_pulse[8] ? r_pulse : w_total) : '0;
      r_valid <= w_pub;
      if (w_pub) begin
        r_speed <= w_total[8] ? SPEED_MAX : w_total[SPEED_W-1:0];
        r_ovf   <= w_total[8];
        r_cmp   <= 1'b1;
      end else if (!run) begin
        r_cmp   <= 1'b0;
      end
    end
  end
  assign speed       = r_speed;
  assign speed_valid = r_valid;
  assign overflow    = r_ovf;
  assign cmp_enable  = r_cmp;
endmodule

// File: tb/tb_wheel_speed_sampler.sv
// tb_wheel_speed_sampler: randomized ticks against an edge-timestamp reference model with a queued scoreboard.
module tb_wheel_speed_sampler;
  import cruise_pkg::*;
  localparam int W  = 1000;
  localparam int SS = 2;
  logic clk = 1'b0, reset_n = 1'b0, run = 1'b0, wheel_tick = 1'b0;
  logic [SPEED_W-1:0] speed;
  logic speed_valid, overflow, cmp_enable;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  wheel_speed_sampler #(.WINDOW_CYCLES(W), .SYNC_STAGES(SS)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .wheel_tick  (wheel_tick),
    .speed       (speed),
    .speed_valid (speed_valid),
    .overflow    (overflow),
    .cmp_enable  (cmp_enable)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask
  // tick generator: manual level, fixed high/low lengths, or random phase lengths
  int hi_len = 5, lo_len = 5, ph = 0;
  bit per_en = 0, rnd = 0;
  logic tick_man = 1'b0;
  initial forever begin
    @(negedge clk);
    #1;
    if (!per_en) wheel_tick = tick_man;
    else if (ph <= 1) begin
      wheel_tick = !wheel_tick;
      ph = wheel_tick ? (rnd ? int'($urandom_range(2, 6)) : hi_len) : (rnd ? int'($urandom_range(2, 6)) : lo_len);
    end else ph--;
  end
  // reference model: a tick sampled high at edge k (low at k-1) is credited at edge k+2;
  // a session starting at edge s publishes at s+1+i*W covering credits from the preceding W edges
  typedef struct {int spd; bit ovf; int edge_n;} exp_t;
  exp_t q[$];
  int n_edge = 0, sess = -1, cnt = 0;
  bit hist[4];
  bit exp_cmp = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_edge = 0; sess = -1; cnt = 0; exp_cmp = 0;
      hist = '{default: 1'b0};
      q.delete();
    end else begin
      n_edge++;
      hist[n_edge % 4] = wheel_tick;
      if (!run) begin
        sess = -1;
        exp_cmp = 0;
      end else begin
        if (sess < 0) begin
          sess = n_edge;
          cnt = 0;
        end else if (n_edge >= sess + 2 && hist[(n_edge - 2) % 4] && !hist[(n_edge - 3) % 4]) cnt++;
        if (n_edge >= sess + W + 1 && (n_edge - sess - 1) % W == 0) begin
          q.push_back('{(cnt > 255) ? 255 : cnt, cnt > 255, n_edge});
          cnt = 0;
          exp_cmp = 1;
        end
      end
    end
  end
  // monitor: pops the scoreboard when a publish is due and checks held outputs every cycle
  int exp_spd = 0;
  bit exp_ovf = 0, due;
  exp_t e_cur;
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_spd = 0;
      exp_ovf = 0;
    end else begin
      due = q.size() > 0 && q[0].edge_n == n_edge;
      check("speed_valid", speed_valid, due);
      if (due) begin
        e_cur = q.pop_front();
        exp_spd = e_cur.spd;
        exp_ovf = e_cur.ovf;
      end else if (q.size() > 0 && q[0].edge_n < n_edge) void'(q.pop_front());
      check("speed", speed, exp_spd);
      check("overflow", overflow, exp_ovf);
      check("cmp_enable", cmp_enable, exp_cmp);
    end
  end
  task automatic wait_valid(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!speed_valid && k < 2 * W + 10);
    check("valid_timeout", speed_valid, 1);
  endtask
  int lat, nv;
  int v[3];
  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_speed", speed, 0);
    check("rst_valid", speed_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_cmp", cmp_enable, 0);
    @(negedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
    per_en = 1; run = 1'b1;
    wait_valid(lat);
    check("first_latency", lat, W + 2);
    check("speed_p10", speed, 100);
    check("cmp_after_pub", cmp_enable, 1);
    wait_valid(lat);
    check("spacing", lat, W);
    hi_len = 2; lo_len = 1;
    wait_valid(lat);
    wait_valid(lat);
    check("speed_p3", speed, 255);
    check("ovf_p3", overflow, 1);
    hi_len = 5; lo_len = 5;
    wait_valid(lat);
    wait_valid(lat);
    check("speed_back", speed, 100);
    check("ovf_back", overflow, 0);
    repeat (500) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    check("stop_cmp", cmp_enable, 0);
    repeat (40) @(negedge clk);
    check("stop_hold", speed, 100);
    run = 1'b1;
    wait_valid(lat);
    check("restart_latency", lat, W + 2);
    repeat (300) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_speed", speed, 0);
    check("async_rst_valid", speed_valid, 0);
    check("async_rst_ovf", overflow, 0);
    check("async_rst_cmp", cmp_enable, 0);
    run = 1'b0;
    @(negedge clk);
    #3 reset_n = 1'b1;
    per_en = 0; tick_man = 1'b1;
    repeat (10) @(negedge clk);
    run = 1'b1;
    nv = 0;
    for (int m = 1; m <= 3 * W + 5; m++) begin
      @(negedge clk);
      if (speed_valid && nv < 3) begin
        v[nv] = speed;
        nv++;
      end
      tick_man = (m == W - 4) ? 1'b0 : (m == W - 1) ? 1'b1 : (m == W + 50) ? 1'b0 : (m == 2 * W) ? 1'b1 : tick_man;
    end
    check("edge_valids", nv, 3);
    check("terminal_edge", v[0], 1);
    check("publish_edge_w2", v[1], 0);
    check("publish_edge_w3", v[2], 1);
    rnd = 1; per_en = 1;
    for (int i = 0; i < 8; i++) begin
      run = 1'b1;
      repeat ($urandom_range(200, 2600)) @(negedge clk);
      run = 1'b0;
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
